// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
//
// Instruction-fetch address source. It holds a registered program counter and
// a small hardware return-address stack. Each clock edge performs exactly one
// action, chosen from the decoded control inputs in this priority order:
//
//   stall > ret_en > call_en > branch_en > increment
//
// Any lower-priority request that arrives in the same cycle is ignored.
//
// Actions:
//   increment  pc <= pc + 1, wrapping modulo 2^ADDR_W.
//   branch     pc <= branch_target.
//   call       pc <= branch_target and push pc + 1.
//              If the stack is already full, the jump is still taken, the push
//              is dropped and stack_overflow is set.
//   return     pc <= top of stack and pop it.
//              If the stack is empty, the action behaves as an increment and
//              stack_underflow is set.
//   stall      pc, stack and depth all hold. err_clr still takes effect.
//
// Both error flags are sticky. They clear only on err_clr or on reset. If an
// error is raised in the same cycle as err_clr, the set wins.
//
// Parameters:
//   ADDR_W       width of pc, branch_target and each stack entry (>= 2)
//   STACK_DEPTH  number of return-address entries (>= 1, any value)
//   RESET_ADDR   pc value on reset, truncated to ADDR_W
//
// Ports:
//   clk              clock; every state update happens on its rising edge
//   rst              asynchronous, active-low reset
//   stall            freeze pc, stack and depth this cycle
//   branch_en        jump to branch_target
//   call_en          jump to branch_target and push pc + 1
//   ret_en           pop the top of stack into pc
//   branch_target    destination for branch and call
//   err_clr          clear both sticky error flags
//   pc               current instruction address (registered)
//   depth            number of valid stack entries (registered)
//   stack_overflow   sticky: a call was made while the stack was full
//   stack_underflow  sticky: a return was made while the stack was empty
// -----------------------------------------------------------------------------
module pc_stack #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic                               branch_en,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic [ADDR_W-1:0]                  branch_target,
    input  logic                               err_clr,
    output logic [ADDR_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    // The index must be at least one bit wide, even for a one-entry stack.
    localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0]  PC_RESET   = ADDR_W'(RESET_ADDR);

    // Elaboration-time parameter sanity checks.
    generate
        if (ADDR_W < 2) begin : g_bad_addr_w
            $error("pc_stack: ADDR_W must be at least 2");
        end
        if (STACK_DEPTH < 1) begin : g_bad_depth
            $error("pc_stack: STACK_DEPTH must be at least 1");
        end
    endgenerate

    // The single action resolved for this cycle, after priority and after the
    // full/empty conditions have been taken into account.
    typedef enum logic [2:0] {
        ACT_HOLD,       // stall
        ACT_INC,        // plain increment, or a return on an empty stack
        ACT_JUMP,       // branch, or a call on a full stack
        ACT_PUSH_JUMP,  // call with room on the stack
        ACT_POP         // return with a valid top entry
    } action_t;

    // Return-address storage. Entries at index depth and above are stale and
    // never read.
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    action_t            action;
    logic               stack_full;
    logic               stack_empty;
    logic               set_overflow;
    logic               set_underflow;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  top_entry;
    logic [ADDR_W-1:0]  pc_next;
    logic [DEPTH_W-1:0] depth_next;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic               overflow_next;
    logic               underflow_next;

    assign stack_full  = (depth == DEPTH_FULL);
    assign stack_empty = (depth == '0);
    // The addition wraps naturally modulo 2^ADDR_W.
    assign pc_inc      = pc + ADDR_W'(1);

    // The push writes slot [depth] and the pop reads slot [depth-1]. A call
    // followed immediately by a return therefore reads the entry that was just
    // written, with no forwarding needed. top_idx is only used when the stack
    // is not empty, so the subtraction never wraps in a case that matters.
    assign push_idx  = IDX_W'(depth);
    assign top_idx   = IDX_W'(depth - DEPTH_W'(1));
    assign top_entry = stack_mem[top_idx];

    // ------------------------------------------------------------------
    // Action decode (priority resolution)
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb block gets a default value
    // first. Otherwise, any path that skips an assignment infers a latch.
    always_comb begin
        action        = ACT_INC;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;

        if (stall) begin
            action = ACT_HOLD;
        end else if (ret_en) begin
            if (stack_empty) begin
                action        = ACT_INC;
                set_underflow = 1'b1;
            end else begin
                action = ACT_POP;
            end
        end else if (call_en) begin
            if (stack_full) begin
                action       = ACT_JUMP;
                set_overflow = 1'b1;
            end else begin
                action = ACT_PUSH_JUMP;
            end
        end else if (branch_en) begin
            action = ACT_JUMP;
        end
    end

    // ------------------------------------------------------------------
    // Next-state values for pc, depth and the sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        pc_next    = pc;
        depth_next = depth;

        case (action)
            ACT_HOLD: begin
                pc_next    = pc;
                depth_next = depth;
            end
            ACT_INC: begin
                pc_next = pc_inc;
            end
            ACT_JUMP: begin
                pc_next = branch_target;
            end
            ACT_PUSH_JUMP: begin
                pc_next    = branch_target;
                depth_next = depth + DEPTH_W'(1);
            end
            ACT_POP: begin
                pc_next    = top_entry;
                depth_next = depth - DEPTH_W'(1);
            end
            default: begin
                pc_next    = pc;
                depth_next = depth;
            end
        endcase
    end

    // A new error takes precedence over a clear in the same cycle.
    assign overflow_next  = set_overflow  | (stack_overflow  & ~err_clr);
    assign underflow_next = set_underflow | (stack_underflow & ~err_clr);

    // ------------------------------------------------------------------
    // Architectural state: pc, depth and flags
    // ------------------------------------------------------------------
    // NOTE: sequential state is always assigned with non-blocking (<=)
    // assignments. All registers then update together from the values they
    // held before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc              <= PC_RESET;
            depth           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            pc              <= pc_next;
            depth           <= depth_next;
            stack_overflow  <= overflow_next;
            stack_underflow <= underflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Stack storage
    // ------------------------------------------------------------------
    // NOTE: the storage array deliberately has no reset. Clearing depth
    // already makes every entry invisible. Leaving the array unreset lets it
    // map onto plain flops or RAM, without a reset net fanning out to every
    // bit.
    always_ff @(posedge clk) begin
        if (action == ACT_PUSH_JUMP) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack
//
// Self-checking bench for pc_stack (ADDR_W=8, STACK_DEPTH=3, RESET_ADDR=0xF0).
//
// The driver applies one set of controls per cycle. For each set it advances a
// behavioural model, which uses a queue for the stack and integer arithmetic
// for pc, and pushes the expected post-edge state onto a scoreboard queue.
// A separate monitor pops that queue shortly after each rising edge and
// compares the expected state against the DUT outputs.
// Asynchronous-reset behaviour is checked directly, between clock edges.
// -----------------------------------------------------------------------------
module tb_pc_stack;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 3;
    localparam int RESET_ADDR  = 'hF0;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);
    localparam int PC_MOD      = 1 << ADDR_W;

    logic               clk;
    logic               rst;
    logic               stall;
    logic               branch_en;
    logic               call_en;
    logic               ret_en;
    logic [ADDR_W-1:0]  branch_target;
    logic               err_clr;
    logic [ADDR_W-1:0]  pc;
    logic [DEPTH_W-1:0] depth;
    logic               stack_overflow;
    logic               stack_underflow;

    pc_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_ADDR  (RESET_ADDR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_en       (branch_en),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .branch_target   (branch_target),
        .err_clr         (err_clr),
        .pc              (pc),
        .depth           (depth),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard and counters
    // ------------------------------------------------------------------
    typedef struct {
        int  pc;
        int  depth;
        bit  ovf;
        bit  unf;
        int  seq;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   seq_no = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    task automatic model_reset();
        m_pc = RESET_ADDR % PC_MOD;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit rt, input bit cl,
                              input bit br, input int tgt, input bit clr);
        bit new_ovf = 1'b0;
        bit new_unf = 1'b0;
        if (!st) begin
            if (rt) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc    = (m_pc + 1) % PC_MOD;
                    new_unf = 1'b1;
                end
            end else if (cl) begin
                if (m_stack.size() < STACK_DEPTH) begin
                    m_stack.push_back((m_pc + 1) % PC_MOD);
                end else begin
                    new_ovf = 1'b1;
                end
                m_pc = tgt;
            end else if (br) begin
                m_pc = tgt;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (new_ovf) m_ovf = 1'b1;
        if (new_unf) m_unf = 1'b1;
    endtask

    // Called on a falling edge. Drives one cycle of controls, records the
    // expected result of the next rising edge, and returns on the following
    // falling edge.
    task automatic step(input bit st, input bit rt, input bit cl, input bit br,
                        input int tgt, input bit clr);
        exp_t e;
        stall         = st;
        ret_en        = rt;
        call_en       = cl;
        branch_en     = br;
        branch_target = ADDR_W'(tgt);
        err_clr       = clr;
        model_step(st, rt, cl, br, tgt, clr);
        e.pc    = m_pc;
        e.depth = m_stack.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.seq   = seq_no++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_branch(input int tgt);
        step(0, 0, 0, 1, tgt, 0);
    endtask

    task automatic do_call(input int tgt);
        step(0, 0, 1, 0, tgt, 0);
    endtask

    task automatic do_ret();
        step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    32'(pc),              32'(RESET_ADDR));
        check({tag, "_depth"}, 32'(depth),           32'd0);
        check({tag, "_ovf"},   32'(stack_overflow),  32'd0);
        check({tag, "_unf"},   32'(stack_underflow), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare the DUT against the scoreboard after each rising edge
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("pc[%0d]", e.seq),    32'(pc),              32'(e.pc));
                check($sformatf("depth[%0d]", e.seq), 32'(depth),           32'(e.depth));
                check($sformatf("ovf[%0d]", e.seq),   32'(stack_overflow),  32'(e.ovf));
                check($sformatf("unf[%0d]", e.seq),   32'(stack_underflow), 32'(e.unf));
            end
        end
    end

    // Watchdog: guarantees the run ends even if the driver gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
                 errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst           = 1'b0;
        stall         = 1'b0;
        branch_en     = 1'b0;
        call_en       = 1'b0;
        ret_en        = 1'b0;
        branch_target = '0;
        err_clr       = 1'b0;
        model_reset();

        // Reset state, then 20 idle cycles (includes the wrap from 0xFF to 0x00).
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        repeat (20) idle();

        // Nested call/return.
        do_branch('h10);
        do_call('h40);
        idle();
        do_call('h80);
        do_ret();
        do_ret();

        // Overflow: four calls into a three-entry stack, then unwind.
        do_branch('h05);
        repeat (4) do_call('h20);
        repeat (3) do_ret();
        step(0, 0, 0, 0, 0, 1);

        // Underflow and clear: set wins over clear in the same cycle.
        do_branch('h30);
        do_ret();
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // The return address pushed by a call at 0xFF wraps to 0x00.
        do_branch('hFF);
        do_call('h50);
        do_ret();

        // Priority: stall beats everything, then return beats call.
        do_call('h60);
        step(1, 1, 1, 1, 'h99, 0);
        step(0, 1, 1, 0, 'h77, 0);
        // Call beats branch.
        step(0, 0, 1, 1, 'h33, 0);
        do_ret();

        // err_clr acts during a stall; no error can be raised while stalled.
        do_ret();
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        repeat (3) do_call('h44);
        step(1, 0, 1, 0, 'h12, 0);
        idle();

        // Asynchronous reset mid-call at depth 3, applied between clock edges.
        while (m_stack.size() > 0) do_ret();
        step(0, 0, 0, 0, 0, 1);
        do_call('h11);
        do_call('h22);
        do_call('h33);
        call_en       = 1'b1;
        branch_target = 8'h44;
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        call_en = 1'b0;
        rst     = 1'b1;
        model_reset();
        do_ret();

        // Randomised traffic, biased so that full and empty stacks occur often.
        for (int i = 0; i < 400; i++) begin
            bit st = ($urandom_range(0, 99) < 12);
            bit rt = ($urandom_range(0, 99) < 35);
            bit cl = ($urandom_range(0, 99) < 40);
            bit br = ($urandom_range(0, 99) < 25);
            bit cr = ($urandom_range(0, 99) < 8);
            step(st, rt, cl, br, int'($urandom_range(0, PC_MOD - 1)), cr);
        end

        // Every expectation must have been consumed by the monitor.
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
